// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Purpose:
//   Shares a 4 x DATA_W register file (1 write port, 2 combinational read
//   ports) between two requesters:
//     req 0 = core control unit
//     req 1 = debug/loader
//   Arbitration is round-robin. Each transaction uses a req/ack handshake:
//     IDLE -> ACCESS (one cycle) -> ACK (one cycle) -> IDLE
//   Every file-side output is registered, so req has no combinational path to
//   ENW, ENR0 or ENR1. All state updates on the falling edge of CLKb.
//
// Ports:
//   CLKb, Rstb           debounced clock (negedge active), async active-low reset
//   req/we/re0/re1 [1:0] per-requester handshake and operation flags
//   wa/ra0/ra1           per-requester addresses, slice i = requester i
//   wd                   per-requester write data, slice i = requester i
//   gnt [1:0]            one-hot owner of the file during ACCESS/ACK
//   ack [1:0]            one-cycle completion pulse to the owner
//   rd0/rd1              registered read data; held when a port is not read
//   D/ENW/WRA            write port of the file
//   ENR0/ENR1/RDA0/RDA1  read ports of the file
//   Q0/Q1                file read data (Z while the matching enable is low)
//   lock [1:0]           present only with REGARB_LOCK_EN
//
// Configuration:
//   REGARB_LOCK_EN  when defined, a requester holding lock[w] and req[w] at the
//                   end of ACK is re-granted directly (no IDLE cycle), for at
//                   most MAX_LOCK consecutive grants. Undefined: no lock port,
//                   plain round-robin.
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 2,
  parameter int MAX_LOCK = 4
) (
  input  logic                CLKb,
  input  logic                Rstb,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [1:0]          re0,
  input  logic [1:0]          re1,
  input  logic [2*ADDR_W-1:0] wa,
  input  logic [2*ADDR_W-1:0] ra0,
  input  logic [2*ADDR_W-1:0] ra1,
  input  logic [2*DATA_W-1:0] wd,
  output logic [1:0]          gnt,
  output logic [1:0]          ack,
  output logic [DATA_W-1:0]   rd0,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   D,
  output logic                ENW,
  output logic [ADDR_W-1:0]   WRA,
  output logic                ENR0,
  output logic                ENR1,
  output logic [ADDR_W-1:0]   RDA0,
  output logic [ADDR_W-1:0]   RDA1,
`ifdef REGARB_LOCK_EN
  input  logic [1:0]          lock,
`endif
  input  logic [DATA_W-1:0]   Q0,
  input  logic [DATA_W-1:0]   Q1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam int                CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  LOCK_MAX = CNT_W'(MAX_LOCK);

  // Without the lock feature the lock path is tied off and folds away, so
  // both builds share one next-state description.
  logic [1:0] lock_i;
`ifdef REGARB_LOCK_EN
  assign lock_i = lock;
`else
  assign lock_i = 2'b00;
`endif

  // State and registered outputs
  state_t             state_q,    state_d;
  logic [1:0]         gnt_q,      gnt_d;
  logic [1:0]         ack_q,      ack_d;
  logic [DATA_W-1:0]  rd0_q,      rd0_d;
  logic [DATA_W-1:0]  rd1_q,      rd1_d;
  logic [DATA_W-1:0]  file_d_q,   file_d_d;
  logic               enw_q,      enw_d;
  logic [ADDR_W-1:0]  wra_q,      wra_d;
  logic               enr0_q,     enr0_d;
  logic               enr1_q,     enr1_d;
  logic [ADDR_W-1:0]  rda0_q,     rda0_d;
  logic [ADDR_W-1:0]  rda1_q,     rda1_d;
  logic               ptr_q,      ptr_d;      // preferred requester on contention
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d; // consecutive grants to the owner

  // Arbitration and field selection
  logic              win;       // IDLE winner
  logic              own;       // current owner (valid in ACCESS/ACK)
  logic              sel;       // requester whose fields get latched
  logic              lock_ok;   // re-grant the owner straight from ACK
  logic              sel_we, sel_re0, sel_re1;
  logic [ADDR_W-1:0] sel_wa, sel_ra0, sel_ra1;
  logic [DATA_W-1:0] sel_wd;

  always_comb begin
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ptr_q;
      default: win = 1'b0;
    endcase
  end

  assign own     = gnt_q[1];
  assign sel     = (state_q == ACK) ? own : win;
  assign lock_ok = lock_i[own] & req[own] & (lock_cnt_q < LOCK_MAX);

  assign sel_we  = we[sel];
  assign sel_re0 = re0[sel];
  assign sel_re1 = re1[sel];
  assign sel_wa  = sel ? wa[2*ADDR_W-1:ADDR_W]  : wa[ADDR_W-1:0];
  assign sel_ra0 = sel ? ra0[2*ADDR_W-1:ADDR_W] : ra0[ADDR_W-1:0];
  assign sel_ra1 = sel ? ra1[2*ADDR_W-1:ADDR_W] : ra1[ADDR_W-1:0];
  assign sel_wd  = sel ? wd[2*DATA_W-1:DATA_W]  : wd[DATA_W-1:0];

  always_comb begin
    // NOTE: every _d starts at its _q value (ack at 0) so no path through the
    // case below leaves a signal unassigned, which would infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = 2'b00;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    file_d_d   = file_d_q;
    enw_d      = enw_q;
    wra_d      = wra_q;
    enr0_d     = enr0_q;
    enr1_d     = enr1_q;
    rda0_d     = rda0_q;
    rda1_d     = rda1_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      IDLE: begin
        enw_d  = 1'b0;
        enr0_d = 1'b0;
        enr1_d = 1'b0;
        if (|req) begin
          enw_d      = sel_we;
          enr0_d     = sel_re0;
          enr1_d     = sel_re1;
          file_d_d   = sel_wd;
          wra_d      = sel_wa;
          rda0_d     = sel_ra0;
          rda1_d     = sel_ra1;
          gnt_d      = sel ? 2'b10 : 2'b01;
          ptr_d      = ~sel;
          lock_cnt_d = CNT_W'(1);
          state_d    = ACCESS;
        end else begin
          lock_cnt_d = '0;
        end
      end

      ACCESS: begin
        // The file writes on this same edge; Q0/Q1 still carry the old
        // contents, so a read of the address being written returns old data.
        if (enr0_q) rd0_d = Q0;
        if (enr1_q) rd1_d = Q1;
        enw_d   = 1'b0;
        enr0_d  = 1'b0;
        enr1_d  = 1'b0;
        ack_d   = gnt_q;
        state_d = ACK;
      end

      ACK: begin
        if (lock_ok) begin
          enw_d      = sel_we;
          enr0_d     = sel_re0;
          enr1_d     = sel_re1;
          file_d_d   = sel_wd;
          wra_d      = sel_wa;
          rda0_d     = sel_ra0;
          rda1_d     = sel_ra1;
          ptr_d      = ~sel;
          lock_cnt_d = lock_cnt_q + 1'b1;
          state_d    = ACCESS;
        end else begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end
      end

      default: begin
        gnt_d   = 2'b00;
        enw_d   = 1'b0;
        enr0_d  = 1'b0;
        enr1_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // An async reset mid-ACCESS clears ENW at once, so the file never sees the
  // aborted write and no ack is produced.
  always_ff @(negedge CLKb or negedge Rstb) begin
    if (!Rstb) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      file_d_q   <= '0;
      enw_q      <= 1'b0;
      wra_q      <= '0;
      enr0_q     <= 1'b0;
      enr1_q     <= 1'b0;
      rda0_q     <= '0;
      rda1_q     <= '0;
      ptr_q      <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      file_d_q   <= file_d_d;
      enw_q      <= enw_d;
      wra_q      <= wra_d;
      enr0_q     <= enr0_d;
      enr1_q     <= enr1_d;
      rda0_q     <= rda0_d;
      rda1_q     <= rda1_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign rd0  = rd0_q;
  assign rd1  = rd1_q;
  assign D    = file_d_q;
  assign ENW  = enw_q;
  assign WRA  = wra_q;
  assign ENR0 = enr0_q;
  assign ENR1 = enr1_q;
  assign RDA0 = rda0_q;
  assign RDA1 = rda1_q;

endmodule
